// File: rtl/sparc_mem_pkg.sv
// Shared definitions for the SPARC data-RAM access controller: op3 codes, FSM
// state encoding, status codes and access-size decode helpers.
package sparc_mem_pkg;

    localparam logic [5:0] OP_LDSB = 6'b001001;
    localparam logic [5:0] OP_LDSH = 6'b001010;
    localparam logic [5:0] OP_LD   = 6'b000000;
    localparam logic [5:0] OP_LDUB = 6'b000001;
    localparam logic [5:0] OP_LDUH = 6'b000010;
    localparam logic [5:0] OP_LDD  = 6'b000011;
    localparam logic [5:0] OP_STB  = 6'b000101;
    localparam logic [5:0] OP_STH  = 6'b000110;
    localparam logic [5:0] OP_ST   = 6'b000100;
    localparam logic [5:0] OP_STD  = 6'b000111;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ACCESS  = 3'd1,
        ST_RELEASE = 3'd2,
        ST_DONE    = 3'd3,
        ST_FAIL    = 3'd4
    } state_t;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

    typedef enum logic [1:0] {
        SZ_BYTE   = 2'd0,
        SZ_HALF   = 2'd1,
        SZ_WORD   = 2'd2,
        SZ_DOUBLE = 2'd3
    } acc_size_t;

    function automatic acc_size_t access_size(input logic [5:0] op);
        case (op)
            OP_LDSB, OP_LDUB, OP_STB: access_size = SZ_BYTE;
            OP_LDSH, OP_LDUH, OP_STH: access_size = SZ_HALF;
            OP_LDD, OP_STD:           access_size = SZ_DOUBLE;
            default:                  access_size = SZ_WORD;
        endcase
    endfunction

    function automatic logic op_legal(input logic [5:0] op);
        case (op)
            OP_LDSB, OP_LDSH, OP_LD, OP_LDUB, OP_LDUH,
            OP_LDD, OP_STB, OP_STH, OP_ST, OP_STD: op_legal = 1'b1;
            default:                               op_legal = 1'b0;
        endcase
    endfunction

    function automatic logic op_is_store(input logic [5:0] op);
        case (op)
            OP_STB, OP_STH, OP_ST, OP_STD: op_is_store = 1'b1;
            default:                       op_is_store = 1'b0;
        endcase
    endfunction

    function automatic logic is_aligned(input acc_size_t sz, input logic [2:0] lo);
        case (sz)
            SZ_BYTE:   is_aligned = 1'b1;
            SZ_HALF:   is_aligned = (lo[0] == 1'b0);
            SZ_WORD:   is_aligned = (lo[1:0] == 2'b00);
            SZ_DOUBLE: is_aligned = (lo == 3'b000);
            default:   is_aligned = 1'b0;
        endcase
    endfunction

    // Doubles are issued to the RAM as two plain word accesses.
    function automatic logic [5:0] ram_op(input logic [5:0] op);
        case (op)
            OP_LDD:  ram_op = OP_LD;
            OP_STD:  ram_op = OP_ST;
            default: ram_op = op;
        endcase
    endfunction

endpackage

// File: rtl/mfc_sync.sv
// Two-flop synchronizer for the RAM's MFC handshake line.
module mfc_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic meta_r;
    logic sync_r;

    // Two-stage capture of the asynchronous handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;
endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store controller in front of the SPARC data RAM: alignment check, MFA/MFC
// handshake, ldd/std split. Define MFC_SYNC_EN to synchronize MFC through mfc_sync.
module mem_access_ctrl
    import sparc_mem_pkg::*;
#(
    parameter int ADDR_W  = 9,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic [5:0]        opcode,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wr_data_hi,
    input  logic [31:0]       wr_data_lo,
    output logic [31:0]       rd_data_hi,
    output logic [31:0]       rd_data_lo,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err,
    output logic              MFA,
    output logic [5:0]        ram_opcode,
    output logic [ADDR_W-1:0] ram_address,
    output logic [31:0]       ram_DataIn,
    input  logic [31:0]       ram_DataOut,
    input  logic              MFC
);
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t            state_r, next_state_s;
    acc_size_t         size_r, req_size_s;
    logic              is_store_r, second_r;
    logic [ADDR_W-1:0] addr_r;
    logic [31:0]       wlo_r;
    logic [CW-1:0]     tmo_cnt_r;
    logic              tmo_hit_s, mfc_s, req_legal_s, req_aligned_s;
    logic              mfa_nxt_s, done_nxt_s, busy_nxt_s;
    logic [1:0]        err_nxt_s;

`ifdef MFC_SYNC_EN
    mfc_sync u_mfc_sync (
        .clk   (clk),
        .reset (reset),
        .d     (MFC),
        .q     (mfc_s)
    );
`else
    assign mfc_s = MFC;
`endif

    assign req_size_s    = access_size(opcode);
    assign req_legal_s   = op_legal(opcode);
    assign req_aligned_s = is_aligned(req_size_s, addr[2:0]);
    assign tmo_hit_s     = (tmo_cnt_r == CW'(TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_r <= ST_IDLE;
        else       state_r <= next_state_s;
    end

    // Next-state logic; MFC takes priority over an expiring timeout.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req) begin
                    if (!req_legal_s || !req_aligned_s) next_state_s = ST_FAIL;
                    else                                next_state_s = ST_ACCESS;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (mfc_s)          next_state_s = ST_RELEASE;
                else if (tmo_hit_s) next_state_s = ST_FAIL;
                else                next_state_s = ST_ACCESS;
            end
            ST_RELEASE: begin
                if (!mfc_s) begin
                    if (size_r == SZ_DOUBLE && !second_r) next_state_s = ST_ACCESS;
                    else                                  next_state_s = ST_DONE;
                end else if (tmo_hit_s) begin
                    next_state_s = ST_FAIL;
                end else begin
                    next_state_s = ST_RELEASE;
                end
            end
            ST_DONE, ST_FAIL: next_state_s = ST_IDLE;
            default:          next_state_s = ST_IDLE;
        endcase
    end

    // Output decode from the next state so the handshake outputs come straight from flops.
    always_comb begin
        mfa_nxt_s  = (next_state_s == ST_ACCESS);
        busy_nxt_s = (next_state_s != ST_IDLE);
        done_nxt_s = (next_state_s == ST_DONE) || (next_state_s == ST_FAIL);
        err_nxt_s  = ERR_OK;
        if (next_state_s == ST_FAIL) begin
            if (state_r == ST_IDLE) err_nxt_s = req_legal_s ? ERR_MISALIGN : ERR_ILLEGAL;
            else                    err_nxt_s = ERR_TIMEOUT;
        end else begin
            err_nxt_s = ERR_OK;
        end
    end

    // Handshake and status output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            MFA  <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            err  <= ERR_OK;
        end else begin
            MFA  <= mfa_nxt_s;
            busy <= busy_nxt_s;
            done <= done_nxt_s;
            err  <= err_nxt_s;
        end
    end

    // Per-edge timeout counter, restarted on every state change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                            tmo_cnt_r <= '0;
        else if (next_state_s != state_r)     tmo_cnt_r <= '0;
        else if (state_r == ST_ACCESS ||
                 state_r == ST_RELEASE)       tmo_cnt_r <= tmo_cnt_r + CW'(1'b1);
        else                                  tmo_cnt_r <= '0;
    end

    // Request latch, RAM drive and read-data capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            size_r      <= SZ_BYTE;
            is_store_r  <= 1'b0;
            second_r    <= 1'b0;
            addr_r      <= '0;
            wlo_r       <= 32'h0;
            ram_opcode  <= 6'b000000;
            ram_address <= '0;
            ram_DataIn  <= 32'h0;
            rd_data_hi  <= 32'h0;
            rd_data_lo  <= 32'h0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req) begin
                        size_r     <= req_size_s;
                        is_store_r <= op_is_store(opcode);
                        second_r   <= 1'b0;
                        addr_r     <= addr;
                        wlo_r      <= wr_data_lo;
                        if (next_state_s == ST_ACCESS) begin
                            ram_opcode  <= ram_op(opcode);
                            ram_address <= addr;
                            ram_DataIn  <= wr_data_hi;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (mfc_s && !is_store_r) begin
                        if (second_r) begin
                            rd_data_lo <= ram_DataOut;
                        end else begin
                            rd_data_hi <= ram_DataOut;
                            if (size_r != SZ_DOUBLE) rd_data_lo <= 32'h0;
                        end
                    end
                end
                ST_RELEASE: begin
                    if (next_state_s == ST_ACCESS) begin
                        second_r    <= 1'b1;
                        ram_address <= addr_r + ADDR_W'(3'd4);
                        ram_DataIn  <= wlo_r;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed vector table, hand-written
// timeout/reset sequences, and random ops against a byte-array reference model.
module tb_mem_access_ctrl;
    localparam int ADDR_W  = 9;
    localparam int TIMEOUT = 16;
`ifdef MFC_SYNC_EN
    localparam int LAT_S = 6;
    localparam int LAT_D = 12;
`else
    localparam int LAT_S = 2;
    localparam int LAT_D = 4;
`endif
    localparam logic [5:0] OP_LDSB = 6'b001001, OP_LDSH = 6'b001010, OP_LD  = 6'b000000,
                           OP_LDUB = 6'b000001, OP_LDUH = 6'b000010, OP_LDD = 6'b000011,
                           OP_STB  = 6'b000101, OP_STH  = 6'b000110, OP_ST  = 6'b000100,
                           OP_STD  = 6'b000111;

    logic        clk = 1'b0;
    logic        reset, req, busy, done, MFA, MFC, hold;
    logic [5:0]  opcode, ram_opcode;
    logic [8:0]  addr, ram_address;
    logic [31:0] wr_data_hi, wr_data_lo, rd_data_hi, rd_data_lo, ram_DataIn, ram_DataOut;
    logic [1:0]  err;

    logic [7:0]  ram [0:511] = '{default: 8'h00};
    logic [7:0]  mdl [0:511] = '{default: 8'h00};
    logic [31:0] exp_hi = 32'h0, exp_lo = 32'h0;
    int          tests = 0, fails = 0, mfa_total = 0;
    logic        mfa_prev = 1'b0;
    logic [5:0]  ops [10] = '{OP_LDSB, OP_LDSH, OP_LD, OP_LDUB, OP_LDUH,
                              OP_LDD, OP_STB, OP_STH, OP_ST, OP_STD};

    typedef struct {
        logic [5:0]  op;
        logic [8:0]  a;
        logic [31:0] whi, wlo;
        logic [1:0]  e;
        int          lat, pulses;
        logic [31:0] hi, lo;
    } vec_t;
    vec_t tbl[$];

    mem_access_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .req(req), .opcode(opcode), .addr(addr),
        .wr_data_hi(wr_data_hi), .wr_data_lo(wr_data_lo),
        .rd_data_hi(rd_data_hi), .rd_data_lo(rd_data_lo),
        .busy(busy), .done(done), .err(err), .MFA(MFA),
        .ram_opcode(ram_opcode), .ram_address(ram_address), .ram_DataIn(ram_DataIn),
        .ram_DataOut(ram_DataOut), .MFC(MFC)
    );

    always #5 clk = ~clk;

    // Zero-time RAM: MFC follows MFA unless the stub is told to stall.
    assign MFC = MFA & ~hold;

    always_comb begin
        case (ram_opcode)
            OP_LDSB: ram_DataOut = {{24{ram[ram_address][7]}}, ram[ram_address]};
            OP_LDUB: ram_DataOut = {24'h0, ram[ram_address]};
            OP_LDSH: ram_DataOut = {{16{ram[ram_address][7]}}, ram[ram_address], ram[ram_address + 9'd1]};
            OP_LDUH: ram_DataOut = {16'h0, ram[ram_address], ram[ram_address + 9'd1]};
            default: ram_DataOut = {ram[ram_address], ram[ram_address + 9'd1],
                                    ram[ram_address + 9'd2], ram[ram_address + 9'd3]};
        endcase
    end

    always @(posedge clk) begin
        if (MFA && !hold) begin
            case (ram_opcode)
                OP_STB: ram[ram_address] <= ram_DataIn[7:0];
                OP_STH: begin
                    ram[ram_address]        <= ram_DataIn[15:8];
                    ram[ram_address + 9'd1] <= ram_DataIn[7:0];
                end
                OP_ST: begin
                    ram[ram_address]        <= ram_DataIn[31:24];
                    ram[ram_address + 9'd1] <= ram_DataIn[23:16];
                    ram[ram_address + 9'd2] <= ram_DataIn[15:8];
                    ram[ram_address + 9'd3] <= ram_DataIn[7:0];
                end
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        if (MFA && !mfa_prev) mfa_total++;
        mfa_prev = MFA;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic int size_of(input logic [5:0] op);
        case (op)
            OP_LDSB, OP_LDUB, OP_STB: return 1;
            OP_LDSH, OP_LDUH, OP_STH: return 2;
            OP_LD, OP_ST:             return 4;
            OP_LDD, OP_STD:           return 8;
            default:                  return 0;
        endcase
    endfunction

    // Reference model: byte-addressed big-endian memory with SPARC load/store semantics.
    task automatic model_op(input logic [5:0] op, input logic [8:0] a, input logic [31:0] whi,
                            input logic [31:0] wlo, output logic [1:0] e, output int lat,
                            output int pulses);
        int n;
        logic [63:0] v;
        bit is_ld, sgn;
        n     = size_of(op);
        is_ld = op inside {OP_LDSB, OP_LDSH, OP_LD, OP_LDUB, OP_LDUH, OP_LDD};
        sgn   = op inside {OP_LDSB, OP_LDSH};
        e = 2'b00; lat = 0; pulses = 0;
        if (n == 0) begin
            e = 2'b11;
        end else if (int'(a) % n != 0) begin
            e = 2'b01;
        end else begin
            lat    = (n == 8) ? LAT_D : LAT_S;
            pulses = (n == 8) ? 2 : 1;
            if (!is_ld) begin
                v = (n == 8) ? {whi, wlo} : {32'h0, whi};
                for (int i = 0; i < n; i++) mdl[(int'(a) + i) % 512] = v[8*(n-1-i) +: 8];
            end else begin
                v = 64'h0;
                for (int i = 0; i < n; i++) v = (v << 8) | 64'(mdl[(int'(a) + i) % 512]);
                if (n == 8) begin
                    exp_hi = v[63:32];
                    exp_lo = v[31:0];
                end else begin
                    exp_hi = v[31:0];
                    if (sgn && v[8*n-1]) exp_hi = exp_hi - (32'h1 << (8*n));
                    exp_lo = 32'h0;
                end
            end
        end
    endtask

    // Issue one request; lat = edges after the accepting edge until done is seen (-1 if never).
    task automatic run_op(input logic [5:0] op, input logic [8:0] a, input logic [31:0] whi,
                          input logic [31:0] wlo, output logic [1:0] ge, output int glat,
                          output int gpulses, output logic gmfa);
        int start;
        @(negedge clk);
        opcode = op; addr = a; wr_data_hi = whi; wr_data_lo = wlo; req = 1'b1;
        start = mfa_total;
        @(posedge clk); #1;
        req = 1'b0;
        glat = -1; ge = 2'bxx; gmfa = 1'bx;
        for (int k = 0; k < 60; k++) begin
            if (done) begin
                glat = k; ge = err; gmfa = MFA;
                break;
            end
            @(posedge clk); #1;
        end
        if (glat >= 0) begin
            chk("busy_at_done", 32'(busy), 32'd1);
            @(posedge clk); #1;
            chk("busy_after_done", 32'(busy), 32'd0);
            chk("done_one_cycle", 32'(done), 32'd0);
        end
        gpulses = mfa_total - start;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  me, ge;
        logic        gm;
        logic [5:0]  o;
        logic [8:0]  a;
        logic [31:0] whi, wlo;
        int          ml, mp, gl, gp, start, dn, n;
        bit          seen;

        reset = 1'b1; req = 1'b0; opcode = 6'b0; addr = 9'd0;
        wr_data_hi = 32'h0; wr_data_lo = 32'h0; hold = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_MFA", 32'(MFA), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_rd_hi", rd_data_hi, 32'h0);
        chk("rst_rd_lo", rd_data_lo, 32'h0);
        chk("rst_ram_DataIn", ram_DataIn, 32'h0);
        chk("rst_ram_opcode", 32'(ram_opcode), 32'd0);
        chk("rst_ram_address", 32'(ram_address), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        tbl.push_back('{OP_ST,   9'd8,   32'hDEADBEEF, 32'h0, 2'b00, LAT_S, 1, 32'h0, 32'h0});
        tbl.push_back('{OP_LD,   9'd8,   32'h0, 32'h0, 2'b00, LAT_S, 1, 32'hDEADBEEF, 32'h0});
        tbl.push_back('{OP_STD,  9'd16,  32'h11112222, 32'h33334444, 2'b00, LAT_D, 2, 32'hDEADBEEF, 32'h0});
        tbl.push_back('{OP_LDD,  9'd16,  32'h0, 32'h0, 2'b00, LAT_D, 2, 32'h11112222, 32'h33334444});
        tbl.push_back('{OP_LDUH, 9'd3,   32'h0, 32'h0, 2'b01, 0, 0, 32'h11112222, 32'h33334444});
        tbl.push_back('{OP_LDD,  9'd12,  32'h0, 32'h0, 2'b01, 0, 0, 32'h11112222, 32'h33334444});
        tbl.push_back('{6'b111111, 9'd0, 32'h0, 32'h0, 2'b11, 0, 0, 32'h11112222, 32'h33334444});
        tbl.push_back('{OP_STB,  9'd40,  32'h00000080, 32'h0, 2'b00, LAT_S, 1, 32'h11112222, 32'h33334444});
        tbl.push_back('{OP_LDSB, 9'd40,  32'h0, 32'h0, 2'b00, LAT_S, 1, 32'hFFFFFF80, 32'h0});
        tbl.push_back('{OP_LDUB, 9'd40,  32'h0, 32'h0, 2'b00, LAT_S, 1, 32'h00000080, 32'h0});
        tbl.push_back('{OP_STH,  9'd42,  32'h1234ABCD, 32'h0, 2'b00, LAT_S, 1, 32'h00000080, 32'h0});
        tbl.push_back('{OP_LDSH, 9'd42,  32'h0, 32'h0, 2'b00, LAT_S, 1, 32'hFFFFABCD, 32'h0});
        tbl.push_back('{OP_LDUH, 9'd42,  32'h0, 32'h0, 2'b00, LAT_S, 1, 32'h0000ABCD, 32'h0});
        tbl.push_back('{OP_LD,   9'd40,  32'h0, 32'h0, 2'b00, LAT_S, 1, 32'h8000ABCD, 32'h0});
        tbl.push_back('{OP_STH,  9'd41,  32'h0, 32'h0, 2'b01, 0, 0, 32'h8000ABCD, 32'h0});
        tbl.push_back('{OP_ST,   9'd2,   32'h0, 32'h0, 2'b01, 0, 0, 32'h8000ABCD, 32'h0});
        tbl.push_back('{OP_STD,  9'd504, 32'hA5A5A5A5, 32'h5A5A5A5A, 2'b00, LAT_D, 2, 32'h8000ABCD, 32'h0});
        tbl.push_back('{OP_LDD,  9'd504, 32'h0, 32'h0, 2'b00, LAT_D, 2, 32'hA5A5A5A5, 32'h5A5A5A5A});
        tbl.push_back('{OP_LD,   9'd508, 32'h0, 32'h0, 2'b00, LAT_S, 1, 32'h5A5A5A5A, 32'h0});

        foreach (tbl[i]) begin
            model_op(tbl[i].op, tbl[i].a, tbl[i].whi, tbl[i].wlo, me, ml, mp);
            run_op(tbl[i].op, tbl[i].a, tbl[i].whi, tbl[i].wlo, ge, gl, gp, gm);
            chk($sformatf("vec%0d_err", i), 32'(ge), 32'(tbl[i].e));
            chk($sformatf("vec%0d_lat", i), 32'(gl), 32'(tbl[i].lat));
            chk($sformatf("vec%0d_mfa_pulses", i), 32'(gp), 32'(tbl[i].pulses));
            chk($sformatf("vec%0d_rd_hi", i), rd_data_hi, tbl[i].hi);
            chk($sformatf("vec%0d_rd_lo", i), rd_data_lo, tbl[i].lo);
        end
        chk("ram_16_19", {ram[16], ram[17], ram[18], ram[19]}, 32'h11112222);
        chk("ram_20_23", {ram[20], ram[21], ram[22], ram[23]}, 32'h33334444);

        // Stalled RAM: ld must time out with MFA dropped and read data untouched.
        hold = 1'b1;
        run_op(OP_LD, 9'd0, 32'h0, 32'h0, ge, gl, gp, gm);
        hold = 1'b0;
        chk("tmo_err", 32'(ge), 32'd2);
        chk("tmo_lat", 32'(gl), 32'(TIMEOUT));
        chk("tmo_MFA_at_done", 32'(gm), 32'd0);
        chk("tmo_mfa_pulses", 32'(gp), 32'd1);
        chk("tmo_rd_hi_held", rd_data_hi, exp_hi);

        // Reset during the second half of an std.
        model_op(OP_ST, 9'd0, 32'hCAFEF00D, 32'h0, me, ml, mp);
        run_op(OP_ST, 9'd0, 32'hCAFEF00D, 32'h0, ge, gl, gp, gm);
        chk("pre_rst_st_err", 32'(ge), 32'd0);
        @(negedge clk);
        opcode = OP_STD; addr = 9'd24; wr_data_hi = 32'h00000001; wr_data_lo = 32'h00000002;
        req = 1'b1; start = mfa_total;
        @(posedge clk); #1;
        req = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk); #1;
            if (mfa_total - start >= 2) begin
                seen = 1'b1;
                break;
            end
        end
        chk("rst_second_half_reached", 32'(seen), 32'd1);
        reset = 1'b1;
        #1;
        chk("midrst_MFA", 32'(MFA), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_rd_hi", rd_data_hi, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        dn = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done) dn++;
        end
        chk("midrst_no_done", 32'(dn), 32'd0);
        for (int i = 0; i < 4; i++) mdl[24 + i] = (i == 3) ? 8'h01 : 8'h00;
        exp_hi = 32'h0; exp_lo = 32'h0;
        model_op(OP_LD, 9'd0, 32'h0, 32'h0, me, ml, mp);
        run_op(OP_LD, 9'd0, 32'h0, 32'h0, ge, gl, gp, gm);
        chk("post_rst_ld_err", 32'(ge), 32'd0);
        chk("post_rst_ld_lat", 32'(gl), 32'(LAT_S));
        chk("post_rst_ld_rd_hi", rd_data_hi, 32'hCAFEF00D);

        // Random traffic against the reference model.
        for (int t = 0; t < 150; t++) begin
            n = $urandom_range(10, 0);
            if (n == 10) begin
                do o = 6'($urandom_range(63, 0)); while (size_of(o) != 0);
            end else begin
                o = ops[n];
            end
            a = 9'($urandom_range(511, 0));
            n = size_of(o);
            if (n > 1 && $urandom_range(3, 0) != 0) a = a & ~9'(n - 1);
            whi = $urandom; wlo = $urandom;
            model_op(o, a, whi, wlo, me, ml, mp);
            run_op(o, a, whi, wlo, ge, gl, gp, gm);
            chk($sformatf("rnd%0d_op%b_a%0d_err", t, o, a), 32'(ge), 32'(me));
            chk($sformatf("rnd%0d_lat", t), 32'(gl), 32'(ml));
            chk($sformatf("rnd%0d_mfa_pulses", t), 32'(gp), 32'(mp));
            chk($sformatf("rnd%0d_rd_hi", t), rd_data_hi, exp_hi);
            chk($sformatf("rnd%0d_rd_lo", t), rd_data_lo, exp_lo);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
